// File: rtl/ccd_seq_pkg.sv
// Shared state encoding and default timing constants for the CCD line sequencer.
package ccd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_READOUT = 3'd3,
        ST_GAP     = 3'd4
    } seq_state_e;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_PIX_NUM    = 2048;
    localparam int DEF_SYNC_LEN   = 8;
    localparam int DEF_EXPOSE_LEN = 5000;
    localparam int DEF_GAP_LEN    = 16;
    localparam int DEF_PIX_DIV    = 2;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; last_o is high while the count sits at zero, so a load of N-1 spans N cycles.
// Load takes effect at the edge; no backpressure, counting never stalls.
module seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/ccd_line_sequencer.sv
// Line timing for the emulated line-scan CCD: SYNC -> EXPOSE -> READOUT -> GAP, all outputs registered.
// One-cycle decision latency from run_in; no backpressure, pixel strobes are free-running once a line starts.
module ccd_line_sequencer
    import ccd_seq_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PIX_NUM    = DEF_PIX_NUM,
    parameter int SYNC_LEN   = DEF_SYNC_LEN,
    parameter int DEF_EXPOSE = DEF_EXPOSE_LEN,
    parameter int GAP_LEN    = DEF_GAP_LEN,
    parameter int PIX_DIV    = DEF_PIX_DIV
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             run_in,
    input  logic             cfg_we_in,
    input  logic [CNT_W-1:0] cfg_expose_in,
    output logic             sh_out,
    output logic             line_start_out,
    output logic             pix_valid_out,
    output logic [CNT_W-1:0] pix_index_out,
    output logic             line_done_out,
    output logic             busy_out
);

    localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(PIX_NUM - 1);
    localparam logic [CNT_W-1:0] EXP_RST   = CNT_W'(DEF_EXPOSE);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] shadow_d;
    logic [CNT_W-1:0] expose_q;
    logic [CNT_W-1:0] expose_d;
    logic [CNT_W-1:0] pix_idx_q;
    logic [CNT_W-1:0] pix_idx_d;
    logic             line_start_q;
    logic             line_start_d;
    logic             pix_valid_q;
    logic             pix_valid_d;
    logic             line_done_q;
    logic             line_done_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_last;
    logic             enter_sync;
    logic             last_pix;
    logic [CNT_W-1:0] expose_load;

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .last_o     (tmr_last)
    );

    assign last_pix    = (pix_idx_q == LAST_PIX);
    assign enter_sync  = (state_d == ST_SYNC) && (state_q != ST_SYNC);
    // A programmed exposure of 0 still occupies one cycle.
    assign expose_load = (expose_q == '0) ? '0 : (expose_q - ONE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (run_in) state_d = ST_SYNC;
            ST_SYNC:    if (tmr_last) state_d = ST_EXPOSE;
            ST_EXPOSE:  if (tmr_last) state_d = ST_READOUT;
            ST_READOUT: if (tmr_last && last_pix) state_d = ST_GAP;
            ST_GAP:     if (tmr_last) state_d = run_in ? ST_SYNC : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // The timer is reloaded on every phase or pixel boundary; strobes are computed a cycle early and registered.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_val      = '0;
        line_start_d = 1'b0;
        pix_valid_d  = 1'b0;
        line_done_d  = 1'b0;
        pix_idx_d    = pix_idx_q;
        expose_d     = expose_q;
        shadow_d     = cfg_we_in ? cfg_expose_in : shadow_q;
        if (enter_sync) begin
            tmr_load     = 1'b1;
            tmr_val      = SYNC_LOAD;
            line_start_d = 1'b1;
            pix_idx_d    = '0;
            expose_d     = shadow_q;
        end else if (tmr_last) begin
            unique case (state_q)
                ST_SYNC: begin
                    tmr_load = 1'b1;
                    tmr_val  = expose_load;
                end
                ST_EXPOSE: begin
                    tmr_load    = 1'b1;
                    tmr_val     = DIV_LOAD;
                    pix_valid_d = 1'b1;
                end
                ST_READOUT: begin
                    tmr_load = 1'b1;
                    if (last_pix) begin
                        tmr_val     = GAP_LOAD;
                        line_done_d = 1'b1;
                    end else begin
                        tmr_val     = DIV_LOAD;
                        pix_valid_d = 1'b1;
                        pix_idx_d   = pix_idx_q + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow_q     <= EXP_RST;
            expose_q     <= EXP_RST;
            pix_idx_q    <= '0;
            line_start_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            expose_q     <= expose_d;
            pix_idx_q    <= pix_idx_d;
            line_start_q <= line_start_d;
            pix_valid_q  <= pix_valid_d;
            line_done_q  <= line_done_d;
        end
    end

    assign sh_out         = (state_q == ST_SYNC);
    assign busy_out       = (state_q != ST_IDLE);
    assign line_start_out = line_start_q;
    assign pix_valid_out  = pix_valid_q;
    assign pix_index_out  = pix_idx_q;
    assign line_done_out  = line_done_q;

endmodule

// File: tb/tb_ccd_line_sequencer.sv
// Bench for ccd_line_sequencer: two configurations driven in lockstep and checked every cycle against a line-offset model.
module tb_ccd_line_sequencer;

    typedef struct {
        int n;
        int s;
        int d;
        int g;
        int def;
    } cfg_t;

    typedef struct {
        bit active;
        int off;
        int e;
        int shadow;
        int idx_hold;
    } mdl_t;

    logic        clk_in;
    logic        rst_in;
    logic        run_in;
    logic        cfg_we_in;
    logic [15:0] cfg_expose_in;

    logic        sh0, ls0, pv0, ld0, bz0;
    logic [15:0] idx0;
    logic        sh1, ls1, pv1, ld1, bz1;
    logic [15:0] idx1;

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   base;
    cfg_t c0;
    cfg_t c1;
    mdl_t m0;
    mdl_t m1;
    int   ls_q0[$];
    int   ls_q1[$];
    int   pv_q0[$];
    int   pv_q1[$];
    int   ld_q0[$];
    int   ld_q1[$];

    ccd_line_sequencer #(
        .CNT_W(16), .PIX_NUM(4), .SYNC_LEN(2), .DEF_EXPOSE(3), .GAP_LEN(2), .PIX_DIV(2)
    ) u_dut0 (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .run_in         (run_in),
        .cfg_we_in      (cfg_we_in),
        .cfg_expose_in  (cfg_expose_in),
        .sh_out         (sh0),
        .line_start_out (ls0),
        .pix_valid_out  (pv0),
        .pix_index_out  (idx0),
        .line_done_out  (ld0),
        .busy_out       (bz0)
    );

    ccd_line_sequencer #(
        .CNT_W(16), .PIX_NUM(1), .SYNC_LEN(2), .DEF_EXPOSE(3), .GAP_LEN(2), .PIX_DIV(1)
    ) u_dut1 (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .run_in         (run_in),
        .cfg_we_in      (cfg_we_in),
        .cfg_expose_in  (cfg_expose_in),
        .sh_out         (sh1),
        .line_start_out (ls1),
        .pix_valid_out  (pv1),
        .pix_index_out  (idx1),
        .line_done_out  (ld1),
        .busy_out       (bz1)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int line_period(input cfg_t c, input int e);
        return c.s + e + c.n * c.d + c.g;
    endfunction

    // Expected outputs from the position within the current line.
    function automatic void mdl_out(input mdl_t m, input cfg_t c,
                                    output int sh, output int ls, output int pv,
                                    output int ld, output int bz, output int idx);
        int r;
        sh  = 0;
        ls  = 0;
        pv  = 0;
        ld  = 0;
        bz  = 0;
        idx = m.idx_hold;
        if (m.active) begin
            bz = 1;
            sh = (m.off < c.s) ? 1 : 0;
            ls = (m.off == 0) ? 1 : 0;
            r  = m.off - c.s - m.e;
            ld = (r == c.n * c.d) ? 1 : 0;
            if (r < 0) begin
                idx = 0;
            end else if (r < c.n * c.d) begin
                idx = r / c.d;
                pv  = ((r % c.d) == 0) ? 1 : 0;
            end else begin
                idx = c.n - 1;
            end
        end
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input cfg_t c, input bit rst,
                                      input bit run, input bit we, input int val);
        mdl_t nx;
        bit   start;
        int   per;
        nx = m;
        if (rst) begin
            nx.active   = 1'b0;
            nx.off      = 0;
            nx.e        = c.def;
            nx.shadow   = c.def;
            nx.idx_hold = 0;
            return nx;
        end
        per   = line_period(c, m.e);
        start = m.active ? ((m.off == per - 1) && run) : run;
        if (m.active) begin
            nx.off = m.off + 1;
            if (nx.off == per) begin
                nx.active   = 1'b0;
                nx.idx_hold = c.n - 1;
            end
        end
        if (start) begin
            nx.active = 1'b1;
            nx.off    = 0;
            nx.e      = (m.shadow == 0) ? 1 : m.shadow;
        end
        if (we) nx.shadow = val;
        return nx;
    endfunction

    task automatic cmp_inst(input string p, input mdl_t m, input cfg_t c,
                            input int sh, input int ls, input int pv,
                            input int ld, input int bz, input int idx);
        int esh, els, epv, eld, ebz, eidx;
        mdl_out(m, c, esh, els, epv, eld, ebz, eidx);
        check_eq({p, ".sh"}, sh, esh);
        check_eq({p, ".line_start"}, ls, els);
        check_eq({p, ".pix_valid"}, pv, epv);
        check_eq({p, ".line_done"}, ld, eld);
        check_eq({p, ".busy"}, bz, ebz);
        check_eq({p, ".pix_index"}, idx, eidx);
    endtask

    // Called at a falling edge: check this cycle's outputs, then drive the inputs sampled at the next rising edge.
    task automatic step(input bit r, input bit run, input bit we, input int val);
        cmp_inst("u0", m0, c0, int'(sh0), int'(ls0), int'(pv0), int'(ld0), int'(bz0), int'(idx0));
        cmp_inst("u1", m1, c1, int'(sh1), int'(ls1), int'(pv1), int'(ld1), int'(bz1), int'(idx1));
        if (ls0) ls_q0.push_back(cyc);
        if (ls1) ls_q1.push_back(cyc);
        if (pv0) pv_q0.push_back(cyc);
        if (pv1) pv_q1.push_back(cyc);
        if (ld0) ld_q0.push_back(cyc);
        if (ld1) ld_q1.push_back(cyc);
        rst_in        = r;
        run_in        = run;
        cfg_we_in     = we;
        cfg_expose_in = 16'(val);
        m0 = mdl_step(m0, c0, r, run, we, val);
        m1 = mdl_step(m1, c1, r, run, we, val);
        cyc++;
        @(negedge clk_in);
    endtask

    task automatic new_scenario();
        step(1'b1, 1'b0, 1'b0, 0);
        ls_q0.delete(); ls_q1.delete();
        pv_q0.delete(); pv_q1.delete();
        ld_q0.delete(); ld_q1.delete();
        base = cyc;
    endtask

    task automatic check_gaps(input string tag, input int q[$], input int first, input int p1,
                              input int p2, input int p3);
        check_eq({tag, ".count_ge4"}, (q.size() >= 4) ? 1 : 0, 1);
        if (q.size() >= 4) begin
            check_eq({tag, ".first"}, q[0] - base, first);
            check_eq({tag, ".period1"}, q[1] - q[0], p1);
            check_eq({tag, ".period2"}, q[2] - q[1], p2);
            check_eq({tag, ".period3"}, q[3] - q[2], p3);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        base   = 0;
        c0 = '{n: 4, s: 2, d: 2, g: 2, def: 3};
        c1 = '{n: 1, s: 2, d: 1, g: 2, def: 3};
        m0 = mdl_step(m0, c0, 1'b1, 1'b0, 1'b0, 0);
        m1 = mdl_step(m1, c1, 1'b1, 1'b0, 1'b0, 0);
        rst_in        = 1'b1;
        run_in        = 1'b0;
        cfg_we_in     = 1'b0;
        cfg_expose_in = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);

        // Single line, run dropped at cycle 3.
        new_scenario();
        repeat (3) step(1'b0, 1'b1, 1'b0, 0);
        repeat (17) step(1'b0, 1'b0, 1'b0, 0);
        check_eq("s1.u0.starts", ls_q0.size(), 1);
        check_eq("s1.u0.pix_count", pv_q0.size(), 4);
        if (pv_q0.size() == 4) begin
            for (int i = 0; i < 4; i++) check_eq("s1.u0.pix_cycle", pv_q0[i] - base, 6 + 2 * i);
        end
        check_eq("s1.u0.done_count", ld_q0.size(), 1);
        if (ld_q0.size() == 1) check_eq("s1.u0.done_cycle", ld_q0[0] - base, 14);
        check_eq("s1.u1.pix_count", pv_q1.size(), 1);
        if (pv_q1.size() == 1) check_eq("s1.u1.pix_cycle", pv_q1[0] - base, 6);
        if (ld_q1.size() >= 1) check_eq("s1.u1.done_cycle", ld_q1[0] - base, 7);

        // Back-to-back lines.
        new_scenario();
        repeat (50) step(1'b0, 1'b1, 1'b0, 0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 0);
        check_gaps("s2.u0", ls_q0, 1, 15, 15, 15);
        check_gaps("s2.u1", ls_q1, 1, 8, 8, 8);

        // Shadow writes: 5 mid-line, then 1 on the edge that enters line 2.
        new_scenario();
        for (int i = 0; i < 60; i++) begin
            if (i == 8)       step(1'b0, 1'b1, 1'b1, 5);
            else if (i == 15) step(1'b0, 1'b1, 1'b1, 1);
            else              step(1'b0, 1'b1, 1'b0, 0);
        end
        repeat (25) step(1'b0, 1'b0, 1'b0, 0);
        check_gaps("s3.u0", ls_q0, 1, 15, 17, 13);
        check_gaps("s3.u1", ls_q1, 1, 8, 8, 6);

        // Exposure of zero behaves as one cycle.
        new_scenario();
        step(1'b0, 1'b0, 1'b1, 0);
        base = cyc;
        repeat (45) step(1'b0, 1'b1, 1'b0, 0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 0);
        check_gaps("s4.u0", ls_q0, 1, 13, 13, 13);
        check_gaps("s4.u1", ls_q1, 1, 6, 6, 6);

        // Reset during READOUT with run held.
        new_scenario();
        for (int i = 0; i < 50; i++) step((i == 9) ? 1'b1 : 1'b0, 1'b1, 1'b0, 0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 0);
        check_eq("s5.u0.starts_ge3", (ls_q0.size() >= 3) ? 1 : 0, 1);
        if (ls_q0.size() >= 3) begin
            check_eq("s5.u0.restart", ls_q0[1] - base, 11);
            check_eq("s5.u0.def_period", ls_q0[2] - ls_q0[1], 15);
        end

        // Randomized traffic with occasional resets and exposure rewrites.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 7)));
        end
        repeat (30) step(1'b0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
